reg_file_sb: RTL

Parametrised successor to the LC-3 8x16 register file.
- Generalised in register count, data width and number of read ports.
- Adds optional write-to-read bypass, a per-register busy scoreboard for the pipelined datapath, and a registered NZP condition-code unit fed from the write port.
- Sits between the decode/issue stage (reads, reservations) and writeback (write port, CC update).

---
 rtl/reg_file_pkg.sv | 35 +++
 rtl/reg_file_scoreboard.sv | 52 +++++
 rtl/reg_file_sb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared constants and helpers for the reg_file_sb register file and
//   anything that reuses its condition-code encoding.
//   Contents:
//     CC_N/CC_Z/CC_P : bit positions of N, Z, P inside the 3-bit CC vector
//     CC_RESET       : CC value after reset (Z set)
//     CC_MAXW        : widest data word cc_of() accepts
//     cc_of()        : NZP code of a data word of a given width
package reg_file_pkg;

   localparam int CC_N = 2;
   localparam int CC_Z = 1;
   localparam int CC_P = 0;

   localparam logic [2:0] CC_RESET = 3'b010;

   localparam int CC_MAXW = 64;

   // Callers pass the word zero-extended to CC_MAXW together with its real
   // width, so the sign bit is data[width-1] and "zero" is the whole word.
   function automatic logic [2:0] cc_of(input logic [CC_MAXW-1:0] data,
                                        input int                 width);
      logic [2:0] cc;
      cc = '0;
      if (data == '0) begin
         cc[CC_Z] = 1'b1;
      end else if (data[width-1]) begin
         cc[CC_N] = 1'b1;
      end else begin
         cc[CC_P] = 1'b1;
      end
      return cc;
   endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   One busy bit per register. A reservation marks the register busy; a
//   write to it clears it. A reservation and a write to the same register
//   in one cycle leave it busy (the reservation is the newer instruction).
//   Indices >= NREGS match no bit and are therefore ignored.
//   Ports:
//     Clk, Reset : clock, synchronous active-high reset (clears all bits)
//     RSV        : reserve RSV_ADDR this cycle
//     RSV_ADDR   : register to reserve
//     WE         : write this cycle (clears WADDR's bit)
//     WADDR      : register being written
//     BUSY       : registered busy bits, bit k = register k
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NREGS = 8,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             RSV,
   input  logic [AW-1:0]    RSV_ADDR,
   input  logic             WE,
   input  logic [AW-1:0]    WADDR,
   output logic [NREGS-1:0] BUSY
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < NREGS; k++) begin
         if (RSV && (RSV_ADDR == AW'(k))) begin
            busy_d[k] = 1'b1;
         end else if (WE && (WADDR == AW'(k))) begin
            busy_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign BUSY = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Parametrised register file with NRD combinational read ports, one write
//   port, optional same-cycle write-to-read bypass, a per-register busy
//   scoreboard and a registered NZP condition-code unit fed from the write
//   port. WIDTH must not exceed reg_file_pkg::CC_MAXW.
//   Ports:
//     Clk, Reset       : clock, synchronous active-high reset
//     WE, WADDR, WDATA : writeback port
//     CC_LD            : load CC from WDATA (only together with WE)
//     RADDR / RDATA    : packed read indices / read data, port i in slice i
//     RD_BUSY          : port i reads a register still reserved
//     RSV, RSV_ADDR    : reserve a destination register at issue
//     BUSY             : raw scoreboard bits
//     CC               : {N,Z,P}
//     REGS             : all registers, register k in slice k
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NREGS  = 8,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   WE,
   input  logic [AW-1:0]          WADDR,
   input  logic [WIDTH-1:0]       WDATA,
   input  logic                   CC_LD,
   input  logic [NRD*AW-1:0]      RADDR,
   output logic [NRD*WIDTH-1:0]   RDATA,
   output logic [NRD-1:0]         RD_BUSY,
   input  logic                   RSV,
   input  logic [AW-1:0]          RSV_ADDR,
   output logic [NREGS-1:0]       BUSY,
   output logic [2:0]             CC,
   output logic [NREGS*WIDTH-1:0] REGS
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [2:0]       cc_q;
   logic [2:0]       cc_d;

   // Storage: a write index >= NREGS matches no register and is dropped.
   for (genvar k = 0; k < NREGS; k++) begin : g_reg
      always_comb begin
         regs_d[k] = regs_q[k];
         if (WE && (WADDR == AW'(k))) begin
            regs_d[k] = WDATA;
         end
      end

      always_ff @(posedge Clk) begin
         if (Reset) begin
            regs_q[k] <= '0;
         end else begin
            regs_q[k] <= regs_d[k];
         end
      end

      assign REGS[k*WIDTH +: WIDTH] = regs_q[k];
   end

   reg_file_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .Clk      (Clk),
      .Reset    (Reset),
      .RSV      (RSV),
      .RSV_ADDR (RSV_ADDR),
      .WE       (WE),
      .WADDR    (WADDR),
      .BUSY     (BUSY)
   );

   // Read ports: the select loop only matches real registers, so an
   // out-of-range index reads 0 and reports not busy without extra logic.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]    raddr;
      logic [WIDTH-1:0] stored;
      logic             busy_hit;
      logic             in_range;
      logic             byp_hit;

      assign raddr = RADDR[i*AW +: AW];

      always_comb begin
         stored   = '0;
         busy_hit = 1'b0;
         in_range = 1'b0;
         for (int k = 0; k < NREGS; k++) begin
            if (raddr == AW'(k)) begin
               stored   = regs_q[k];
               busy_hit = BUSY[k];
               in_range = 1'b1;
            end
         end
      end

      // A forwarded write also satisfies a pending reservation.
      assign byp_hit = (BYPASS != 0) && WE && (WADDR == raddr) && in_range;

      assign RDATA[i*WIDTH +: WIDTH] = byp_hit ? WDATA : stored;
      assign RD_BUSY[i]              = busy_hit && !byp_hit;
   end

   // CC follows every qualified write, even to an out-of-range index.
   always_comb begin
      cc_d = cc_q;
      if (WE && CC_LD) begin
         cc_d = cc_of(CC_MAXW'(WDATA), WIDTH);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cc_q <= CC_RESET;
      end else begin
         cc_q <= cc_d;
      end
   end

   assign CC = cc_q;

endmodule
